// File: rtl/spi_pin_conditioner.sv
// -----------------------------------------------------------------------------
// spi_pin_conditioner
//   Front end of the SPI slave. Each raw pin (sclk, cs, mosi) passes through
//   a 2-flop synchronizer and then a debounce counter. The conditioned sclk
//   and cs levels also produce registered single-cycle edge pulses. The
//   rising_sclk pulse is the bit-step strobe for the SPI control FSM.
//
//   Optional feature macro: SPI_GLITCH_COUNT_EN
//     When defined, an 8-bit saturating glitch_count output is added. It
//     counts the debounce windows that were abandoned because the pin fell
//     back to the conditioned level before the wait time ran out.
// -----------------------------------------------------------------------------
module spi_pin_conditioner #(
    parameter int COUNTER_WIDTH = 3,
    parameter int WAIT_TIME     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       cs,
    input  logic       mosi,
    output logic       conditioned_sclk,
    output logic       conditioned_cs,
    output logic       conditioned_mosi,
    output logic       rising_sclk,
    output logic       falling_sclk,
    output logic       cs_assert,
    output logic       cs_deassert
`ifdef SPI_GLITCH_COUNT_EN
    ,
    output logic [7:0] glitch_count
`endif
);

    // Channel indices into the packed per-pin vectors.
    localparam int NUM_CH  = 3;
    localparam int CH_SCLK = 0;
    localparam int CH_CS   = 1;
    localparam int CH_MOSI = 2;

    // Reset levels {mosi, cs, sclk}: sclk low, cs idle high, mosi low.
    localparam logic [NUM_CH-1:0] RESET_LEVELS = 3'b010;

    localparam logic [COUNTER_WIDTH-1:0] WAIT_CNT = COUNTER_WIDTH'(WAIT_TIME);
    localparam logic [COUNTER_WIDTH-1:0] CNT_ZERO = {COUNTER_WIDTH{1'b0}};
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);

    // Raw pins gathered into one vector so every channel shares the same logic.
    logic [NUM_CH-1:0] pin_s;

    // Synchronizer stages and the debounced levels.
    logic [NUM_CH-1:0] sync0_r;
    logic [NUM_CH-1:0] sync1_r;
    logic [NUM_CH-1:0] cond_r;
    logic [NUM_CH-1:0] cond_nxt_s;

    // Per-channel debounce counters.
    logic [COUNTER_WIDTH-1:0] cnt_r     [NUM_CH];
    logic [COUNTER_WIDTH-1:0] cnt_nxt_s [NUM_CH];

    // Registered edge pulses.
    logic rising_sclk_r;
    logic falling_sclk_r;
    logic cs_assert_r;
    logic cs_deassert_r;

    assign pin_s = {mosi, cs, sclk};

    // Debounce next-state: restart on match, commit after the wait, else count.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cond_nxt_s[i] = cond_r[i];
            cnt_nxt_s[i]  = cnt_r[i];
            if (sync1_r[i] == cond_r[i]) begin
                cnt_nxt_s[i] = CNT_ZERO;
            end else if (cnt_r[i] == WAIT_CNT) begin
                cond_nxt_s[i] = sync1_r[i];
                cnt_nxt_s[i]  = CNT_ZERO;
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end
        end
    end

    // Synchronizer, debounce state and edge pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync0_r        <= RESET_LEVELS;
            sync1_r        <= RESET_LEVELS;
            cond_r         <= RESET_LEVELS;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
            rising_sclk_r  <= 1'b0;
            falling_sclk_r <= 1'b0;
            cs_assert_r    <= 1'b0;
            cs_deassert_r  <= 1'b0;
        end else begin
            sync0_r        <= pin_s;
            sync1_r        <= sync0_r;
            cond_r         <= cond_nxt_s;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
            // Pulses are registered together with the level, so they line up.
            rising_sclk_r  <= ~cond_r[CH_SCLK] &  cond_nxt_s[CH_SCLK];
            falling_sclk_r <=  cond_r[CH_SCLK] & ~cond_nxt_s[CH_SCLK];
            cs_assert_r    <=  cond_r[CH_CS]   & ~cond_nxt_s[CH_CS];
            cs_deassert_r  <= ~cond_r[CH_CS]   &  cond_nxt_s[CH_CS];
        end
    end

    assign conditioned_sclk = cond_r[CH_SCLK];
    assign conditioned_cs   = cond_r[CH_CS];
    assign conditioned_mosi = cond_r[CH_MOSI];
    assign rising_sclk      = rising_sclk_r;
    assign falling_sclk     = falling_sclk_r;
    assign cs_assert        = cs_assert_r;
    assign cs_deassert      = cs_deassert_r;

`ifdef SPI_GLITCH_COUNT_EN
    // A glitch is a channel whose window was open and has just closed on a match.
    logic [NUM_CH-1:0] glitch_s;
    logic [1:0]        glitch_inc_s;
    logic [8:0]        glitch_sum_s;
    logic [7:0]        glitch_nxt_s;
    logic [7:0]        glitch_count_r;

    // Glitch detection and saturating accumulation of this cycle's glitches.
    always_comb begin
        glitch_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            glitch_s[i] = (cnt_r[i] != CNT_ZERO) && (sync1_r[i] == cond_r[i]);
        end
        glitch_inc_s = {1'b0, glitch_s[0]} + {1'b0, glitch_s[1]} + {1'b0, glitch_s[2]};
        glitch_sum_s = {1'b0, glitch_count_r} + {7'b0000000, glitch_inc_s};
        if (glitch_sum_s[8]) begin
            glitch_nxt_s = 8'hFF;
        end else begin
            glitch_nxt_s = glitch_sum_s[7:0];
        end
    end

    // Glitch counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            glitch_count_r <= 8'h00;
        end else begin
            glitch_count_r <= glitch_nxt_s;
        end
    end

    assign glitch_count = glitch_count_r;
`endif

endmodule
